// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants and types for the LCD serial link receiver
package lcd_pkg;

  localparam int NUM_COLS_DEF = 84;
  localparam int NUM_ROWS_DEF = 6;
  localparam int COL_W        = 7;
  localparam int ROW_W        = 3;

  localparam logic [7:0] FUNC_SET = 8'h20;
  localparam logic [7:0] SET_X    = 8'h80;
  localparam logic [7:0] SET_Y    = 8'h40;

  typedef struct packed {
    logic [7:0]       data;
    logic             is_data;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } lcd_byte_t;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/lcd_spi_deser.sv
// rtl/lcd_spi_deser.sv - link synchronisers, SCLK edge detect and MSB-first byte deserialiser
module lcd_spi_deser
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       sclk_i,
  input  logic       sdin_i,
  input  logic       dnc_i,
  input  logic       nsce_i,
  output logic       done_o,
  output logic [7:0] byte_o,
  output logic       dnc_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sdin_sync_q, dnc_sync_q, nsce_sync_q;
  logic                   sclk_dly_q;
  logic                   sclk_s, sdin_s, dnc_s, nsce_s, sclk_rise;

  rx_state_e  state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [6:0] shift_q, shift_d;
  logic       done_q, done_d;
  logic [7:0] byte_q, byte_d;
  logic       dnc_q, dnc_d;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sclk_sync_q <= '0;
      sdin_sync_q <= '0;
      dnc_sync_q  <= '0;
      nsce_sync_q <= '1;
      sclk_dly_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], sdin_i};
      dnc_sync_q  <= {dnc_sync_q[SYNC_STAGES-2:0], dnc_i};
      nsce_sync_q <= {nsce_sync_q[SYNC_STAGES-2:0], nsce_i};
      sclk_dly_q  <= sclk_s;
    end
  end

  // Equal-depth chains keep SDIN/DnC aligned with the detected SCLK rise.
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdin_s    = sdin_sync_q[SYNC_STAGES-1];
  assign dnc_s     = dnc_sync_q[SYNC_STAGES-1];
  assign nsce_s    = nsce_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= RX_IDLE;
      count_q <= 3'd0;
      shift_q <= 7'd0;
      done_q  <= 1'b0;
      byte_q  <= 8'd0;
      dnc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      byte_q  <= byte_d;
      dnc_q   <= dnc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (!nsce_s) state_d = RX_SHIFT;
      RX_SHIFT: if (nsce_s)  state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // An edge coinciding with nSCE release is still counted, so the last bit can complete a byte.
  always_comb begin
    count_d = count_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    byte_d  = byte_q;
    dnc_d   = dnc_q;
    if (state_q == RX_SHIFT && sclk_rise) begin
      shift_d = {shift_q[5:0], sdin_s};
      if (count_q == 3'd7) begin
        done_d  = 1'b1;
        byte_d  = {shift_q, sdin_s};
        dnc_d   = dnc_s;
        count_d = 3'd0;
      end else begin
        count_d = count_q + 3'd1;
      end
    end
    if (state_q != RX_SHIFT || nsce_s) count_d = 3'd0;
  end

  assign done_o = done_q;
  assign byte_o = byte_q;
  assign dnc_o  = dnc_q;

endmodule

// File: rtl/lcd_spi_receiver.sv
// rtl/lcd_spi_receiver.sv - PCD8544-style LCD link monitor: address/mode tracking and one-deep output
module lcd_spi_receiver
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_COLS    = NUM_COLS_DEF,
  parameter int NUM_ROWS    = NUM_ROWS_DEF
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             SCLK,
  input  logic             SDIN,
  input  logic             DnC,
  input  logic             nSCE,
  output logic [7:0]       RxByte,
  output logic             RxIsData,
  output logic [COL_W-1:0] RxCol,
  output logic [ROW_W-1:0] RxRow,
  output logic             RxValid,
  input  logic             RxReady,
  output logic             Overrun,
  input  logic             ClearOverrun,
  output logic             ExtMode,
  output logic             PowerDown
);

  logic       rx_done, rx_dnc;
  logic [7:0] rx_byte;

  lcd_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .Clock  (Clock),
    .nReset (nReset),
    .sclk_i (SCLK),
    .sdin_i (SDIN),
    .dnc_i  (DnC),
    .nsce_i (nSCE),
    .done_o (rx_done),
    .byte_o (rx_byte),
    .dnc_o  (rx_dnc)
  );

  lcd_byte_t        out_q, out_d;
  logic             valid_q, valid_d, ovr_q, ovr_d;
  logic             ext_q, ext_d, pd_q, pd_d;
  logic [COL_W-1:0] x_q, x_d;
  logic [ROW_W-1:0] y_q, y_d;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ext_q   <= 1'b0;
      pd_q    <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ext_q   <= ext_d;
      pd_q    <= pd_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Controller state follows every completed byte, even one dropped at the output.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    ext_d = ext_q;
    pd_d  = pd_q;
    if (rx_done) begin
      if (rx_dnc) begin
        if (int'(x_q) >= NUM_COLS - 1) begin
          x_d = '0;
          if (int'(y_q) >= NUM_ROWS - 1) y_d = '0;
          else                           y_d = y_q + ROW_W'(1);
        end else begin
          x_d = x_q + COL_W'(1);
        end
      end else if ((rx_byte & 8'hF8) == FUNC_SET) begin
        pd_d  = rx_byte[2];
        ext_d = rx_byte[0];
      end else if (!ext_q) begin
        if ((rx_byte & SET_X) == SET_X) begin
          if (int'(rx_byte[6:0]) >= NUM_COLS) x_d = COL_W'(NUM_COLS - 1);
          else                                x_d = rx_byte[6:0];
        end else if ((rx_byte & 8'hF8) == SET_Y) begin
          if (int'(rx_byte[2:0]) >= NUM_ROWS) y_d = ROW_W'(NUM_ROWS - 1);
          else                                y_d = rx_byte[2:0];
        end
      end
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = ovr_q && !ClearOverrun;
    if (rx_done) begin
      if (!valid_q || RxReady) begin
        out_d.data    = rx_byte;
        out_d.is_data = rx_dnc;
        out_d.col     = rx_dnc ? x_q : '0;
        out_d.row     = rx_dnc ? y_q : '0;
        valid_d       = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && RxReady) begin
      valid_d = 1'b0;
    end
  end

  assign RxByte    = out_q.data;
  assign RxIsData  = out_q.is_data;
  assign RxCol     = out_q.col;
  assign RxRow     = out_q.row;
  assign RxValid   = valid_q;
  assign Overrun   = ovr_q;
  assign ExtMode   = ext_q;
  assign PowerDown = pd_q;

endmodule

// File: tb/tb_lcd_spi_receiver.sv
// tb/tb_lcd_spi_receiver.sv - scoreboard bench for lcd_spi_receiver with a linear-address reference model
module tb_lcd_spi_receiver;
  import lcd_pkg::*;

  localparam int S  = 2;
  localparam int NC = 84;
  localparam int NR = 6;

  logic Clock = 1'b0, nReset = 1'b0;
  logic SCLK = 1'b0, SDIN = 1'b0, DnC = 1'b0, nSCE = 1'b1;
  logic RxReady = 1'b0, ClearOverrun = 1'b0;
  logic [7:0] RxByte;
  logic RxIsData, RxValid, Overrun, ExtMode, PowerDown;
  logic [COL_W-1:0] RxCol;
  logic [ROW_W-1:0] RxRow;

  always #5 Clock = ~Clock;

  lcd_spi_receiver #(.SYNC_STAGES(S), .NUM_COLS(NC), .NUM_ROWS(NR)) dut (
    .Clock(Clock), .nReset(nReset), .SCLK(SCLK), .SDIN(SDIN), .DnC(DnC), .nSCE(nSCE),
    .RxByte(RxByte), .RxIsData(RxIsData), .RxCol(RxCol), .RxRow(RxRow),
    .RxValid(RxValid), .RxReady(RxReady), .Overrun(Overrun), .ClearOverrun(ClearOverrun),
    .ExtMode(ExtMode), .PowerDown(PowerDown)
  );

  int tests = 0;
  int fails = 0;
  logic [18:0] sb[$];
  int m_x, m_y, m_ext, m_pd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {byte, is_data, col, row} is compared whenever the consumer accepts a byte.
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge Clock);
      if (nReset && RxValid && RxReady) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got byte 0x%0h with nothing expected", RxByte);
        end else begin
          e = sb.pop_front();
          check("rx_out", {13'd0, RxByte, RxIsData, RxCol, RxRow}, {13'd0, e});
        end
      end
    end
  end

  task automatic model_reset();
    m_x = 0; m_y = 0; m_ext = 0; m_pd = 1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit dc, output logic [18:0] tag);
    int v, lin;
    v = int'(b);
    if (dc) begin
      tag = {b, 1'b1, 7'(m_x), 3'(m_y)};
      lin = m_y * NC + m_x + 1;
      if (lin >= NC * NR) lin = 0;
      m_x = lin % NC;
      m_y = lin / NC;
    end else begin
      tag = {b, 1'b0, 7'd0, 3'd0};
      if (v >= 32 && v <= 39) begin
        m_pd  = (v >> 2) & 1;
        m_ext = v & 1;
      end else if (m_ext == 0 && v >= 128) begin
        m_x = (v - 128 > NC - 1) ? NC - 1 : v - 128;
      end else if (m_ext == 0 && v >= 64 && v <= 71) begin
        m_y = (v - 64 > NR - 1) ? NR - 1 : v - 64;
      end
    end
  endtask

  task automatic send_bit(input bit v, input bit dc, input bit measure);
    int first;
    @(posedge Clock); #1;
    SDIN = v;
    DnC  = dc;
    repeat ($urandom_range(S + 1, S + 3)) @(posedge Clock);
    #1 SCLK = 1'b1;
    if (measure) begin
      first = 0;
      for (int k = 1; k <= S + 3; k++) begin
        @(posedge Clock); #1;
        if (first == 0 && RxValid) first = k;
      end
      check("latency", first, S + 2);
    end else begin
      repeat ($urandom_range(S + 1, S + 3)) @(posedge Clock);
    end
    #1 SCLK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit dc, input bit expect_out);
    logic [18:0] tag;
    bit meas;
    model_byte(b, dc, tag);
    if (expect_out) sb.push_back(tag);
    meas = expect_out && RxReady;
    for (int i = 7; i >= 0; i--) send_bit(b[i], dc, meas && (i == 0));
    repeat (S + 4) @(posedge Clock);
    #1;
    check("ext_mode", ExtMode, m_ext);
    check("power_down", PowerDown, m_pd);
  endtask

  task automatic select_link();
    @(posedge Clock); #1 nSCE = 1'b0;
    repeat (S + 2) @(posedge Clock);
  endtask

  task automatic deselect_link();
    @(posedge Clock); #1 nSCE = 1'b1;
    repeat (S + 3) @(posedge Clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte"}, RxByte, 0);
    check({tag, "_isdata"}, RxIsData, 0);
    check({tag, "_col"}, RxCol, 0);
    check({tag, "_row"}, RxRow, 0);
    check({tag, "_valid"}, RxValid, 0);
    check({tag, "_overrun"}, Overrun, 0);
    check({tag, "_ext"}, ExtMode, 0);
    check({tag, "_pd"}, PowerDown, 1);
  endtask

  initial begin
    logic [7:0] b;
    bit dc;
    int wait_cnt;

    model_reset();
    repeat (3) @(posedge Clock);
    #1 check_reset_values("reset");
    nReset = 1'b1;
    repeat (2) @(posedge Clock);
    #1 RxReady = 1'b1;

    select_link();
    send_byte(8'h21, 1'b0, 1'b1);
    send_byte(8'h20, 1'b0, 1'b1);
    send_byte(8'hD3, 1'b0, 1'b1);
    send_byte(8'h42, 1'b0, 1'b1);
    send_byte(8'hAA, 1'b1, 1'b1);
    send_byte(8'h55, 1'b1, 1'b1);
    send_byte(8'hFF, 1'b0, 1'b1);
    send_byte(8'h47, 1'b0, 1'b1);
    send_byte(8'h0F, 1'b1, 1'b1);
    send_byte(8'hD3, 1'b0, 1'b1);
    send_byte(8'h45, 1'b0, 1'b1);
    send_byte(8'h81, 1'b1, 1'b1);
    send_byte(8'h7E, 1'b1, 1'b1);
    send_byte(8'h21, 1'b0, 1'b1);
    send_byte(8'h85, 1'b0, 1'b1);
    send_byte(8'h43, 1'b0, 1'b1);
    send_byte(8'h20, 1'b0, 1'b1);
    send_byte(8'h11, 1'b1, 1'b1);

    @(posedge Clock); #1 RxReady = 1'b0;
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    check("held_valid", RxValid, 1);
    check("overrun_set", Overrun, 1);
    @(posedge Clock); #1 ClearOverrun = 1'b1;
    @(posedge Clock); #1 ClearOverrun = 1'b0;
    check("overrun_clear", Overrun, 0);
    RxReady = 1'b1;
    repeat (4) @(posedge Clock);
    send_byte(8'h04, 1'b1, 1'b1);

    for (int i = 7; i >= 3; i--) send_bit(i[0], 1'b1, 1'b0);
    deselect_link();
    select_link();
    send_byte(8'h3C, 1'b1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      dc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = 8'h20 | 8'($urandom_range(0, 7));
        1:       b = 8'h80 | 8'($urandom_range(0, 127));
        2:       b = 8'h40 | 8'($urandom_range(0, 7));
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_byte(b, dc, 1'b1);
    end

    send_byte(8'h21, 1'b0, 1'b1);
    send_byte(8'h20, 1'b0, 1'b1);
    send_byte(8'h9A, 1'b0, 1'b1);
    for (int i = 7; i >= 4; i--) send_bit(i[0], 1'b1, 1'b0);
    @(posedge Clock); #1;
    nReset = 1'b0;
    nSCE = 1'b1;
    SCLK = 1'b0;
    #1 check_reset_values("mid_reset");
    sb.delete();
    model_reset();
    repeat (3) @(posedge Clock);
    #1 nReset = 1'b1;
    repeat (2) @(posedge Clock);
    select_link();
    send_byte(8'hC3, 1'b1, 1'b1);
    send_byte(8'h3C, 1'b1, 1'b1);
    deselect_link();

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 200) begin
      @(posedge Clock);
      wait_cnt++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
